// File: rtl/x_top_mem_bridge.sv
`timescale 1ns / 1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | x_top_mem_bridge                                                     |
// | Memory request to byte-serial UART bridge with echo check, byte      |
// | strobes, configurable address/data width and an rx timeout.          |
// | Also holds the x_top_uart_tx / x_top_uart_rx 8N1 sub-blocks.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+

// 8N1 transmitter: accepts a byte whenever idle and shifts it out LSB first.
module x_top_uart_tx #(
  parameter int p_clk_hz = 1000000,
  parameter int p_baud   = 9600
) (
  input  logic       i_clk,
  input  logic       i_nrst,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  output logic       o_accept,
  output logic       o_tx
);
  localparam int DIV = p_clk_hz / p_baud;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(DIV - 1);

  logic [9:0]    shreg;
  logic [3:0]    bits_left;
  logic [CW-1:0] baud_cnt;

  assign o_accept = i_valid && (bits_left == 4'd0);
  assign o_tx     = shreg[0];

  // Frame shifter; the register idles at all ones so the line rests high.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      shreg     <= '1;
      bits_left <= 4'd0;
      baud_cnt  <= '0;
    end else if (o_accept) begin
      shreg     <= {1'b1, i_data, 1'b0};
      bits_left <= 4'd10;
      baud_cnt  <= '0;
    end else if (bits_left != 4'd0) begin
      if (baud_cnt == BIT_LAST) begin
        baud_cnt  <= '0;
        shreg     <= {1'b1, shreg[9:1]};
        bits_left <= bits_left - 4'd1;
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
    end
  end
endmodule

// 8N1 receiver: synchronises the line, samples mid-bit, pulses o_valid on a good stop bit.
module x_top_uart_rx #(
  parameter int p_clk_hz = 1000000,
  parameter int p_baud   = 9600
) (
  input  logic       i_clk,
  input  logic       i_nrst,
  input  logic       i_rx,
  output logic       o_valid,
  output logic [7:0] o_data
);
  localparam int DIV = p_clk_hz / p_baud;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF     = CW'(DIV / 2);

  logic [1:0]    sync;
  logic          active;
  logic [3:0]    bitn;
  logic [CW-1:0] cnt;
  logic [7:0]    shreg;
  wire           rxd = sync[1];

  assign o_data = shreg;

  // Start detection, mid-bit sampling and stop-bit validation.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      sync    <= 2'b11;
      active  <= 1'b0;
      bitn    <= 4'd0;
      cnt     <= '0;
      shreg   <= 8'h00;
      o_valid <= 1'b0;
    end else begin
      sync    <= {sync[0], i_rx};
      o_valid <= 1'b0;
      if (!active) begin
        if (!rxd) begin
          active <= 1'b1;
          cnt    <= HALF;
          bitn   <= 4'd0;
        end
      end else if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end else begin
        cnt <= BIT_LAST;
        if (bitn == 4'd0) begin
          // A start bit that has gone high again by mid-bit was a glitch.
          if (rxd) active <= 1'b0;
          else     bitn   <= 4'd1;
        end else if (bitn != 4'd9) begin
          shreg <= {rxd, shreg[7:1]};
          bitn  <= bitn + 4'd1;
        end else begin
          active  <= 1'b0;
          o_valid <= rxd;
        end
      end
    end
  end
endmodule

// Bridge top: request capture, byte sequencing, echo check and timeout.
module x_top_mem_bridge #(
  parameter int p_clk_hz     = 1000000,
  parameter int p_baud       = 9600,
  parameter int p_addr_bytes = 4,
  parameter int p_data_bytes = 4,
  parameter int p_timeout    = 100000
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_valid,
  input  logic                      i_rnw,
  input  logic [8*p_addr_bytes-1:0] i_addr,
  input  logic [8*p_data_bytes-1:0] i_data,
  input  logic [p_data_bytes-1:0]   i_strb,
  output logic                      o_accept,
  output logic                      o_error,
  output logic [8*p_data_bytes-1:0] o_data,
  output logic                      o_busy,
  input  logic                      i_rx,
  output logic                      o_tx
);
  localparam logic [3:0] IDLE  = 4'd0;
  localparam logic [3:0] CMD   = 4'd1;
  localparam logic [3:0] ADDR  = 4'd2;
  localparam logic [3:0] STRB  = 4'd3;
  localparam logic [3:0] WDATA = 4'd4;
  localparam logic [3:0] ECHO  = 4'd5;
  localparam logic [3:0] RDATA = 4'd6;
  localparam logic [3:0] RACK  = 4'd7;
  localparam logic [3:0] RESP  = 4'd8;

  localparam logic [1:0] ADDR_LAST = 2'(p_addr_bytes - 1);
  localparam logic [1:0] DATA_LAST = 2'(p_data_bytes - 1);
  localparam int TW = (p_timeout > 0) ? $clog2(p_timeout + 1) : 1;
  localparam logic [TW-1:0] TOUT_LAST = (p_timeout > 0) ? TW'(p_timeout - 1) : '0;

  logic [3:0]                state, phase;
  logic                      rnw_q, err;
  logic [8*p_addr_bytes-1:0] addr_q;
  logic [8*p_data_bytes-1:0] data_q, rbuf, data_out;
  logic [p_data_bytes-1:0]   strb_q;
  logic [1:0]                idx;
  logic [7:0]                last_byte, tx_byte, rx_data;
  logic [TW-1:0]             tcnt;
  logic                      tx_valid, tx_accept, rx_valid, timeout_hit;
  wire                       nrst = ~i_rst;

  assign o_accept    = (state == RESP);
  assign o_error     = (state == RESP) && err;
  assign o_busy      = (state != IDLE);
  assign o_data      = data_out;
  assign timeout_hit = (p_timeout != 0) && (tcnt == TOUT_LAST);

  x_top_uart_tx #(.p_clk_hz(p_clk_hz), .p_baud(p_baud)) u_tx (
    .i_clk(i_clk), .i_nrst(nrst), .i_valid(tx_valid), .i_data(tx_byte),
    .o_accept(tx_accept), .o_tx(o_tx)
  );

  x_top_uart_rx #(.p_clk_hz(p_clk_hz), .p_baud(p_baud)) u_rx (
    .i_clk(i_clk), .i_nrst(nrst), .i_rx(i_rx), .o_valid(rx_valid), .o_data(rx_data)
  );

  // Byte offered to the transmitter in each sending state.
  always_comb begin
    tx_valid = 1'b0;
    tx_byte  = 8'h00;
    case (state)
      CMD:   begin tx_valid = 1'b1; tx_byte = rnw_q ? 8'hF0 : 8'h0F; end
      ADDR:  begin tx_valid = 1'b1; tx_byte = addr_q[8*idx +: 8]; end
      STRB:  begin tx_valid = 1'b1; tx_byte = 8'(strb_q); end
      WDATA: begin tx_valid = 1'b1; tx_byte = data_q[8*idx +: 8]; end
      RACK:  begin tx_valid = 1'b1; tx_byte = 8'h00; end
      default: ;
    endcase
  end

  // Transaction sequencer; phase remembers which sending state an ECHO belongs to.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      phase     <= IDLE;
      rnw_q     <= 1'b0;
      err       <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      strb_q    <= '0;
      rbuf      <= '0;
      data_out  <= '0;
      idx       <= 2'd0;
      last_byte <= 8'h00;
      tcnt      <= '0;
    end else begin
      case (state)
        IDLE: if (i_valid) begin
          rnw_q  <= i_rnw;
          addr_q <= i_addr;
          data_q <= i_data;
          strb_q <= i_strb;
          err    <= 1'b0;
          idx    <= 2'd0;
          // A write that enables no lanes has nothing to send.
          state  <= (!i_rnw && (i_strb == '0)) ? RESP : CMD;
        end
        CMD, ADDR, STRB, WDATA: if (tx_accept) begin
          last_byte <= tx_byte;
          phase     <= state;
          tcnt      <= '0;
          state     <= ECHO;
        end
        ECHO: begin
          if (rx_valid) begin
            tcnt <= '0;
            if (rx_data != last_byte) begin
              err   <= 1'b1;
              state <= RESP;
            end else begin
              case (phase)
                CMD: begin idx <= 2'd0; state <= ADDR; end
                ADDR: if (idx == ADDR_LAST) begin
                  idx   <= 2'd0;
                  state <= rnw_q ? RDATA : STRB;
                end else begin
                  idx   <= idx + 2'd1;
                  state <= ADDR;
                end
                STRB: begin idx <= 2'd0; state <= WDATA; end
                default: if (idx == DATA_LAST) begin
                  state <= RESP;
                end else begin
                  idx   <= idx + 2'd1;
                  state <= WDATA;
                end
              endcase
            end
          end else if (timeout_hit) begin
            err   <= 1'b1;
            state <= RESP;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        RDATA: begin
          if (rx_valid) begin
            rbuf[8*idx +: 8] <= rx_data;
            state            <= RACK;
          end else if (timeout_hit) begin
            err   <= 1'b1;
            state <= RESP;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        RACK: if (tx_accept) begin
          if (idx == DATA_LAST) begin
            // Only a fully successful read reaches here, so publish the buffer now.
            data_out <= rbuf;
            state    <= RESP;
          end else begin
            idx   <= idx + 2'd1;
            tcnt  <= '0;
            state <= RDATA;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_x_top_mem_bridge.sv
`timescale 1ns / 1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_x_top_mem_bridge                                                  |
// | Directed bench with a byte-level remote model on the UART pins.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_x_top_mem_bridge;
  localparam int DIV    = 8;
  localparam int BUDGET = 5000;
  localparam logic [1:0] M_LOOP = 2'd0, M_READ = 2'd1, M_BAD = 2'd2, M_SILENT = 2'd3;

  typedef struct packed {
    logic        sel;
    logic [1:0]  mode;
    logic        rnw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] data;
    logic [3:0]  len;
    logic [79:0] log;
    logic [11:0] lat;
  } vec_t;

  logic        clk = 1'b0, rst = 1'b1;
  logic        valid_a = 1'b0, valid_b = 1'b0;
  logic        req_rnw = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_strb = '0;
  logic        acc_a, err_a, busy_a, tx_a, acc_b, err_b, busy_b, tx_b;
  logic [31:0] data_a;
  logic [15:0] data_b;
  logic        rx_line;
  logic        sel = 1'b0;
  logic [1:0]  mode = M_SILENT;
  logic [31:0] cur_rdata = '0;
  logic [7:0]  tx_log[$];
  logic [7:0]  send_q[$];
  logic [7:0]  dec_byte, snd_byte;
  int          n_cmp = 0, n_bad = 0;
  vec_t        vecs[7];
  wire         rem_line = sel ? tx_b : tx_a;

  always #5 clk = ~clk;

  x_top_mem_bridge #(.p_clk_hz(DIV), .p_baud(1), .p_addr_bytes(4), .p_data_bytes(4),
                     .p_timeout(1000)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_valid(valid_a), .i_rnw(req_rnw), .i_addr(req_addr),
    .i_data(req_wdata), .i_strb(req_strb), .o_accept(acc_a), .o_error(err_a),
    .o_data(data_a), .o_busy(busy_a), .i_rx(rx_line), .o_tx(tx_a)
  );

  x_top_mem_bridge #(.p_clk_hz(DIV), .p_baud(1), .p_addr_bytes(2), .p_data_bytes(2),
                     .p_timeout(1000)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_valid(valid_b), .i_rnw(req_rnw), .i_addr(req_addr[15:0]),
    .i_data(req_wdata[15:0]), .i_strb(req_strb[1:0]), .o_accept(acc_b), .o_error(err_b),
    .o_data(data_b), .o_busy(busy_b), .i_rx(rx_line), .o_tx(tx_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Remote side: log every byte the bridge sends and queue the reply for it.
  function automatic void respond(input logic [7:0] b);
    int n, nb, k;
    tx_log.push_back(b);
    n  = tx_log.size() - 1;
    nb = sel ? 2 : 4;
    case (mode)
      M_LOOP: send_q.push_back(b);
      M_BAD: begin
        if (n == 0)      send_q.push_back(b);
        else if (n == 1) send_q.push_back(b ^ 8'h01);
      end
      M_READ: begin
        if (n <= nb) begin
          send_q.push_back(b);
          if (n == nb) send_q.push_back(cur_rdata[7:0]);
        end else begin
          k = n - nb;
          if (k < nb) send_q.push_back(cur_rdata[8*k +: 8]);
        end
      end
      default: ;
    endcase
  endfunction

  // Byte decoder on the selected bridge's tx line.
  initial begin
    forever begin
      @(negedge clk);
      if (rem_line == 1'b0) begin
        repeat (DIV / 2) @(negedge clk);
        if (rem_line == 1'b0) begin
          for (int i = 0; i < 8; i++) begin
            repeat (DIV) @(negedge clk);
            dec_byte[i] = rem_line;
          end
          repeat (DIV) @(negedge clk);
          if (rem_line) respond(dec_byte);
        end
      end
    end
  end

  // Byte sender driving the shared rx line.
  initial begin
    rx_line = 1'b1;
    forever begin
      @(negedge clk);
      if (send_q.size() != 0) begin
        snd_byte = send_q.pop_front();
        rx_line  = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          rx_line = snd_byte[i];
          repeat (DIV) @(negedge clk);
        end
        rx_line = 1'b1;
        repeat (DIV) @(negedge clk);
      end
    end
  end

  task automatic run_req(input logic s, input logic rnw, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb,
                         output logic ok, output logic err, output logic [31:0] data,
                         output int lat);
    req_rnw = rnw; req_addr = addr; req_wdata = wdata; req_strb = strb;
    if (s) valid_b = 1'b1; else valid_a = 1'b1;
    ok = 1'b0; err = 1'b0; data = '0; lat = 0;
    for (int i = 1; i <= BUDGET && !ok; i++) begin
      @(negedge clk);
      if (s ? acc_b : acc_a) begin
        ok   = 1'b1;
        lat  = i;
        err  = s ? err_b : err_a;
        data = s ? {16'h0, data_b} : data_a;
      end
    end
    valid_a = 1'b0;
    valid_b = 1'b0;
  endtask

  task automatic check_log(input string tag, input logic [3:0] len, input logic [79:0] exp);
    logic [7:0] act;
    check({tag, " tx_count"}, tx_log.size(), {28'h0, len});
    for (int i = 0; i < len; i++) begin
      act = (i < tx_log.size()) ? tx_log[i] : 8'hxx;
      check($sformatf("%s tx_byte%0d", tag, i), {24'h0, act}, {24'h0, exp[8*i +: 8]});
    end
  endtask

  initial begin
    logic        ok, err;
    logic [31:0] data;
    int          lat, accs;

    vecs[0] = '{1'b0, M_LOOP, 1'b0, 32'h12345678, 32'hCAFEBABE, 4'hF, 32'h0, 1'b0, 32'h0,
                4'd10, 80'hCAFEBABE0F123456780F, 12'd0};
    vecs[1] = '{1'b0, M_READ, 1'b1, 32'h00000010, 32'h0, 4'h0, 32'h11223344, 1'b0, 32'h11223344,
                4'd9, 80'h0000000000000010F0, 12'd0};
    vecs[2] = '{1'b0, M_BAD, 1'b0, 32'h12345678, 32'hDEADBEEF, 4'hF, 32'h0, 1'b1, 32'h11223344,
                4'd2, 80'h780F, 12'd0};
    vecs[3] = '{1'b0, M_LOOP, 1'b0, 32'hFFFFFFFF, 32'h55555555, 4'h0, 32'h0, 1'b0, 32'h11223344,
                4'd0, 80'h0, 12'd1};
    vecs[4] = '{1'b0, M_LOOP, 1'b0, 32'h000000A5, 32'h01020304, 4'h5, 32'h0, 1'b0, 32'h11223344,
                4'd10, 80'h0102030405000000A50F, 12'd0};
    vecs[5] = '{1'b1, M_READ, 1'b1, 32'h00001234, 32'h0, 4'h0, 32'h0000BEEF, 1'b0, 32'h0000BEEF,
                4'd5, 80'h00001234F0, 12'd0};
    vecs[6] = '{1'b0, M_BAD, 1'b1, 32'h00000010, 32'h0, 4'h0, 32'h0, 1'b1, 32'h11223344,
                4'd2, 80'h10F0, 12'd0};

    // Reset state of both instances.
    repeat (3) @(negedge clk);
    check("rst accept", {31'h0, acc_a | acc_b}, 32'h0);
    check("rst error", {31'h0, err_a | err_b}, 32'h0);
    check("rst data_a", data_a, 32'h0);
    check("rst data_b", {16'h0, data_b}, 32'h0);
    check("rst busy", {31'h0, busy_a | busy_b}, 32'h0);
    check("rst tx", {30'h0, tx_a, tx_b}, 32'h3);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      tx_log.delete();
      send_q.delete();
      sel = vecs[v].sel; mode = vecs[v].mode; cur_rdata = vecs[v].rdata;
      run_req(vecs[v].sel, vecs[v].rnw, vecs[v].addr, vecs[v].wdata, vecs[v].strb,
              ok, err, data, lat);
      check($sformatf("v%0d accept_seen", v), {31'h0, ok}, 32'h1);
      check($sformatf("v%0d error", v), {31'h0, err}, {31'h0, vecs[v].err});
      check($sformatf("v%0d data", v), data, vecs[v].data);
      if (vecs[v].lat != 0) check($sformatf("v%0d latency", v), lat, {20'h0, vecs[v].lat});
      @(negedge clk);
      check($sformatf("v%0d busy_after", v), {31'h0, sel ? busy_b : busy_a}, 32'h0);
      check($sformatf("v%0d accept_pulse", v), {31'h0, sel ? acc_b : acc_a}, 32'h0);
      repeat (250) @(negedge clk);
      check_log($sformatf("v%0d", v), vecs[v].len, vecs[v].log);
    end

    // Silent remote: error exactly 1000 cycles after ECHO entry (1002 from request).
    tx_log.delete(); send_q.delete(); sel = 1'b0; mode = M_SILENT;
    run_req(1'b0, 1'b0, 32'h0, 32'h0, 4'hF, ok, err, data, lat);
    check("tmo accept_seen", {31'h0, ok}, 32'h1);
    check("tmo latency", lat, 32'd1002);
    check("tmo error", {31'h0, err}, 32'h1);
    check("tmo data_kept", data, 32'h11223344);
    @(negedge clk);
    check("tmo busy_after", {31'h0, busy_a}, 32'h0);
    repeat (100) @(negedge clk);

    // Reset while the first write-data byte is on the wire.
    tx_log.delete(); send_q.delete(); mode = M_LOOP; accs = 0;
    req_rnw = 1'b0; req_addr = 32'h12345678; req_wdata = 32'hCAFEBABE; req_strb = 4'hF;
    valid_a = 1'b1;
    @(negedge clk);
    valid_a = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < BUDGET && !ok; i++) begin
      @(negedge clk);
      accs += acc_a;
      if (tx_log.size() >= 5 && tx_a == 1'b0) ok = 1'b1;
    end
    check("rstmid reached_wdata", {31'h0, ok}, 32'h1);
    repeat (20) @(negedge clk);
    rst = 1'b1; mode = M_SILENT;
    @(negedge clk);
    check("rstmid tx", {31'h0, tx_a}, 32'h1);
    check("rstmid busy", {31'h0, busy_a}, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      accs += acc_a;
    end
    check("rstmid no_accept", accs, 32'h0);
    tx_log.delete(); send_q.delete(); mode = M_LOOP;
    run_req(1'b0, 1'b0, 32'h12345678, 32'hCAFEBABE, 4'hF, ok, err, data, lat);
    check("after_rst accept_seen", {31'h0, ok}, 32'h1);
    check("after_rst error", {31'h0, err}, 32'h0);
    repeat (250) @(negedge clk);
    check_log("after_rst", 4'd10, 80'hCAFEBABE0F123456780F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
